// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder sequencer with operand/result valid-ready handshakes
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CNT_W-1:0] bit_cnt;

    // Single shared 1-bit stage: two cascaded half adders plus the carry flop.
    logic             ha1_s, ha1_c, ha2_s, ha2_c, carry_next;
    logic [WIDTH-1:0] sum_sh_next;

    assign ha1_s       = a_sh[0] ^ b_sh[0];
    assign ha1_c       = a_sh[0] & b_sh[0];
    assign ha2_s       = ha1_s ^ carry;
    assign ha2_c       = ha1_s & carry;
    assign carry_next  = ha1_c | ha2_c;
    assign sum_sh_next = {ha2_s, sum_sh[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            bit_cnt   <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && !abort) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        carry    <= cin;
                        sum_sh   <= '0;
                        bit_cnt  <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        sum_sh  <= sum_sh_next;
                        a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
                        b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
                        carry   <= carry_next;
                        bit_cnt <= bit_cnt + 1'b1;
                        // Result registers only change here, so a partial sum is never visible.
                        if (bit_cnt == LAST_BIT) begin
                            sum       <= sum_sh_next;
                            cout      <= carry_next;
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (abort || out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl at WIDTH 8, 2 and 32
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid8, in_ready8, cin8, abort8, out_valid8, out_ready8, cout8, busy8;
    logic [7:0] a8, b8, sum8;

    logic       iv2, ir2, cin2, ov2, or2, cout2, busy2;
    logic [1:0] a2, b2, sum2;
    logic        iv32, ir32, cin32, ov32, or32, cout32, busy32;
    logic [31:0] a32, b32, sum32;
    logic        abort_w;

    int vectors = 0;
    int fails   = 0;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .abort(abort8), .out_valid(out_valid8),
        .out_ready(out_ready8), .sum(sum8), .cout(cout8), .busy(busy8)
    );

    serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
        .a(a2), .b(b2), .cin(cin2), .abort(abort_w), .out_valid(ov2),
        .out_ready(or2), .sum(sum2), .cout(cout2), .busy(busy2)
    );

    serial_add_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .a(a32), .b(b32), .cin(cin32), .abort(abort_w), .out_valid(ov32),
        .out_ready(or32), .sum(sum32), .cout(cout32), .busy(busy32)
    );

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference for the WIDTH=8 instance: phase plus countdown of remaining bits.
    int         m_phase = 0;
    int         m_left  = 0;
    logic [8:0] m_pend  = '0;
    logic [7:0] m_sum   = '0;
    logic       m_cout  = 1'b0;
    bit         m_live  = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            m_sum   = '0;
            m_cout  = 1'b0;
            m_live  = 1'b1;
        end else begin
            case (m_phase)
                0: if (in_valid8 && !abort8) begin
                    m_pend  = 9'(a8) + 9'(b8) + 9'(cin8);
                    m_left  = 8;
                    m_phase = 1;
                end
                1: if (abort8) m_phase = 0;
                   else begin
                       m_left--;
                       if (m_left == 0) begin
                           m_phase = 2;
                           {m_cout, m_sum} = m_pend;
                       end
                   end
                default: if (abort8 || out_ready8) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("in_ready8", in_ready8, longint'(m_phase == 0));
            check("out_valid8", out_valid8, longint'(m_phase == 2));
            check("busy8", busy8, longint'(m_phase != 0));
            check("sum8", sum8, m_sum);
            check("cout8", cout8, m_cout);
        end
    end

    task automatic send8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        in_valid8 = 1'b1;
        a8 = av;
        b8 = bv;
        cin8 = cv;
        @(negedge clk);
        in_valid8 = 1'b0;
    endtask

    task automatic wait_valid8(output int lat);
        lat = 0;
        while (!out_valid8 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid8) check("wait8_timeout", out_valid8, 1);
    endtask

    function automatic logic w_ov(input int k);
        return (k == 0) ? ov2 : ov32;
    endfunction

    task automatic op_w(input int k, input longint av, input longint bv, input logic cv,
                        input int stall, output longint s, output logic co);
        int n;
        check(k == 0 ? "w2_in_ready" : "w32_in_ready", (k == 0) ? ir2 : ir32, 1);
        if (k == 0) begin iv2 = 1'b1; a2 = av[1:0]; b2 = bv[1:0]; cin2 = cv; end
        else begin iv32 = 1'b1; a32 = av[31:0]; b32 = bv[31:0]; cin32 = cv; end
        @(negedge clk);
        iv2 = 1'b0;
        iv32 = 1'b0;
        check(k == 0 ? "w2_busy" : "w32_busy", (k == 0) ? busy2 : busy32, 1);
        n = 0;
        while (!w_ov(k) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!w_ov(k)) check("w_timeout", w_ov(k), 1);
        repeat (stall) @(negedge clk);
        if (k == 0) begin s = longint'(sum2); co = cout2; or2 = 1'b1; end
        else begin s = longint'(sum32); co = cout32; or32 = 1'b1; end
        @(negedge clk);
        or2 = 1'b0;
        or32 = 1'b0;
    endtask

    typedef struct {logic [7:0] a; logic [7:0] b; logic c; logic [7:0] s; logic co;} vec_t;
    vec_t carry_tab[3] = '{
        '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1},
        '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1},
        '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1}
    };

    initial begin
        int     lat;
        longint s, expv, mask;
        logic   co;

        rst_n = 1'b0;
        in_valid8 = 0; a8 = 0; b8 = 0; cin8 = 0; abort8 = 0; out_ready8 = 1'b1;
        iv2 = 0; a2 = 0; b2 = 0; cin2 = 0; or2 = 0;
        iv32 = 0; a32 = 0; b32 = 0; cin32 = 0; or32 = 0;
        abort_w = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", in_ready8, 1);
        check("rst_out_valid", out_valid8, 0);
        check("rst_sum", sum8, 0);
        check("rst_busy", busy8, 0);

        send8(8'h3C, 8'h5A, 1'b0);
        check("accept_in_ready", in_ready8, 0);
        wait_valid8(lat);
        check("latency", lat, 8);
        check("basic_sum", sum8, 8'h96);
        check("basic_cout", cout8, 0);
        @(negedge clk);
        check("basic_idle", in_ready8, 1);

        foreach (carry_tab[i]) begin
            send8(carry_tab[i].a, carry_tab[i].b, carry_tab[i].c);
            wait_valid8(lat);
            check("carry_sum", sum8, carry_tab[i].s);
            check("carry_cout", cout8, carry_tab[i].co);
            @(negedge clk);
        end

        out_ready8 = 1'b0;
        send8(8'h10, 8'h20, 1'b0);
        in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        repeat (2) @(negedge clk);
        in_valid8 = 1'b0;
        wait_valid8(lat);
        for (int i = 0; i < 5; i++) begin
            in_valid8 = 1'b1; a8 = 8'h77; b8 = 8'h01;
            check("bp_sum", sum8, 8'h30);
            check("bp_busy", busy8, 1);
            @(negedge clk);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(negedge clk);
        check("bp_release", in_ready8, 1);
        send8(8'h01, 8'h02, 1'b0);
        wait_valid8(lat);
        check("bp_next_sum", sum8, 8'h03);
        @(negedge clk);

        send8(8'h40, 8'h40, 1'b0);
        repeat (3) @(negedge clk);
        abort8 = 1'b1;
        @(negedge clk);
        abort8 = 1'b0;
        check("abort_in_ready", in_ready8, 1);
        check("abort_sum_kept", sum8, 8'h03);
        for (int i = 0; i < 10; i++) begin
            check("abort_no_valid", out_valid8, 0);
            @(negedge clk);
        end
        abort8 = 1'b1; in_valid8 = 1'b1; a8 = 8'h05;
        @(negedge clk);
        abort8 = 1'b0; in_valid8 = 1'b0;
        check("abort_idle_busy", busy8, 0);
        @(negedge clk);

        send8(8'h0F, 8'h0F, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mrst_in_ready", in_ready8, 1);
        check("mrst_out_valid", out_valid8, 0);
        check("mrst_sum", sum8, 0);
        check("mrst_cout", cout8, 0);
        check("mrst_busy", busy8, 0);
        send8(8'h12, 8'h34, 1'b0);
        wait_valid8(lat);
        check("post_rst_sum", sum8, 8'h46);
        check("post_rst_cout", cout8, 0);
        @(negedge clk);

        op_w(0, 3, 3, 1'b1, 0, s, co);
        check("w2_max_sum", s, 3);
        check("w2_max_cout", co, 1);

        for (int k = 0; k < 2; k++) begin
            mask = (k == 0) ? 64'h3 : 64'hFFFF_FFFF;
            for (int i = 0; i < 1000; i++) begin
                longint av, bv;
                logic   cv;
                av = longint'($urandom) & mask;
                bv = longint'($urandom) & mask;
                cv = 1'($urandom_range(0, 1));
                expv = av + bv + longint'(cv);
                op_w(k, av, bv, cv, int'($urandom_range(0, 3)), s, co);
                check(k == 0 ? "w2_sum" : "w32_sum", s, expv & mask);
                check(k == 0 ? "w2_cout" : "w32_cout", co, (expv >> (k == 0 ? 2 : 32)) & 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder sequencer. It accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake. It then steps a single 1-bit add stage (two cascaded half-adder cells plus a carry flop) once per clock, LSB first. The WIDTH-bit sum and carry-out are returned over a second valid/ready handshake. This trades WIDTH cycles of latency for one shared 1-bit adder instead of a WIDTH-bit ripple chain.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  synchronous reset, active-low.
in_valid  input  1  operands a, b, cin are valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in.
abort  input  1  synchronous abort of the operation in flight.
out_valid  output  1  sum/cout are valid.
out_ready  input  1  downstream accepts the result.
sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
cout  output  1  carry out of bit WIDTH-1.
busy  output  1  high in RUN or DONE.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low. Reset has priority over every other input.
- Reset (rst_n=0 at an edge):
  - state=IDLE; internal operand, sum-shift and bit-count registers cleared; carry flop cleared.
  - Outputs after reset: in_ready=1, out_valid=0, sum=0, cout=0, busy=0.
- States:
  - IDLE: in_ready=1. On an edge with in_valid=1 and abort=0:
    - capture a, b, carry flop=cin, bit_cnt=0; go to RUN.
  - RUN: in_ready=0. Each edge:
    - s_i = a_sh[0]^b_sh[0]^c; c_next = (a_sh[0]&b_sh[0]) | (c&(a_sh[0]^b_sh[0])).
    - s_i shifts into the sum register MSB; a_sh and b_sh shift right; bit_cnt increments.
    - On the edge where bit_cnt==WIDTH-1, the final bit is processed and the state goes to DONE.
  - DONE: out_valid=1. sum holds the full result; cout holds the final carry.
    - sum and cout stay stable while out_valid=1 and out_ready=0.
    - On an edge with out_ready=1: go to IDLE, out_valid=0.
- Latency:
  - Accept edge T, then out_valid=1 in the cycle after edge T+WIDTH, so exactly WIDTH RUN cycles.
  - Minimum issue interval is WIDTH+2 cycles: accept, WIDTH RUN, DONE with out_ready=1, back in IDLE.
- Result registers:
  - sum and cout hold the last completed result while in IDLE.
  - They are not exposed mid-computation: the output regs update only on the RUN→DONE edge. The internal shift register is separate.
- in_valid in RUN or DONE: ignored, no capture. No same-edge re-accept out of DONE; in_ready is 0 in DONE.
- abort:
  - In RUN or DONE: next state IDLE; out_valid=0; the partial result is discarded, so sum/cout keep their prior value.
  - In IDLE: ignored, and it blocks acceptance on that edge.
  - abort has priority over the in/out handshakes. rst_n has priority over abort.
- Reset mid-RUN or mid-DONE: immediate return to the reset values above. No output is produced for the discarded operation.
- Width rules:
  - bit_cnt is ceil(log2(WIDTH)) bits wide.
  - Sum wraps modulo 2^WIDTH; overflow is reported only through cout.
- busy = (state != IDLE). in_ready = (state == IDLE).
- All outputs are registered or decoded directly from state. There is no combinational path from inputs to outputs.

Test Plan:
- WIDTH=8: a=0x3C, b=0x5A, cin=0, out_ready=1.
  - Response: in_ready drops after the accept edge; out_valid rises exactly 8 cycles later with sum=0x96, cout=0; IDLE on the following edge.
- Carry chain:
  - 0xFF+0x01, cin=0 → sum=0x00, cout=1.
  - 0xFF+0x00, cin=1 → sum=0x00, cout=1.
  - 0xAA+0x55, cin=1 → sum=0x00, cout=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid rises.
  - Response: sum/cout stable, busy=1. in_valid pulsed with new operands during RUN and DONE is not captured.
  - Raise out_ready → IDLE; the next accept works normally.
- Abort: assert abort for one cycle when bit_cnt=3.
  - Response: IDLE next edge, in_ready=1, out_valid never asserted, sum/cout unchanged from the previous result.
  - Abort held in IDLE together with in_valid → no accept.
- Reset mid-RUN: rst_n=0 for one edge at bit_cnt=5.
  - Response: in_ready=1, out_valid=0, sum=0, cout=0, busy=0. A subsequent 0x12+0x34 gives 0x46, cout=0.
- Back-to-back with a random reference model, WIDTH=2 and WIDTH=32:
  - 1000 random operand/cin sets with random out_ready stalls; every result matches (a+b+cin).
  - WIDTH=2 case: 0x3+0x3+1 → sum=0x3, cout=1.
